// File: rtl/bf_core.sv
// Brainfuck core: fetches ASCII instructions from a 1-cycle sync ROM, operates on
// cells in a 1-cycle sync RAM and strobes output bytes; loops resolved by pc scanning.
module bf_core #(
  parameter int DATA_ADDR_WIDTH  = 16,
  parameter int DATA_VALUE_WIDTH = 32,
  parameter int PROG_ADDR_WIDTH  = 16,
  parameter int PROG_VALUE_WIDTH = 10
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en,
  output logic [PROG_ADDR_WIDTH-1:0]  prog_addr,
  output logic                        prog_ren,
  input  logic [PROG_VALUE_WIDTH-1:0] prog_rval,
  output logic [DATA_ADDR_WIDTH-1:0]  data_addr,
  output logic                        data_ren,
  output logic                        data_wen,
  output logic [DATA_VALUE_WIDTH-1:0] data_wval,
  input  logic [DATA_VALUE_WIDTH-1:0] data_rval,
  output logic [7:0]                  stdout,
  output logic                        stdout_en
);

  localparam logic [7:0] OP_RIGHT = 8'h3E;
  localparam logic [7:0] OP_LEFT  = 8'h3C;
  localparam logic [7:0] OP_INC   = 8'h2B;
  localparam logic [7:0] OP_DEC   = 8'h2D;
  localparam logic [7:0] OP_OUT   = 8'h2E;
  localparam logic [7:0] OP_OPEN  = 8'h5B;
  localparam logic [7:0] OP_CLOSE = 8'h5D;
  localparam logic [7:0] OP_HALT  = 8'h00;

  localparam logic [PROG_ADDR_WIDTH-1:0]  P_ONE = 1;
  localparam logic [DATA_ADDR_WIDTH-1:0]  A_ONE = 1;
  localparam logic [DATA_VALUE_WIDTH-1:0] V_ONE = 1;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_LOAD, S_EXEC, S_SFETCH, S_SDEC, S_HALT
  } state_t;

  state_t                     state, state_nxt;
  logic [PROG_ADDR_WIDTH-1:0] pc, pc_nxt;
  logic [DATA_ADDR_WIDTH-1:0] dp, dp_nxt;
  logic [PROG_ADDR_WIDTH-1:0] depth, depth_nxt, scan_depth;
  logic                       back, back_nxt;
  logic [7:0]                 ir, ir_nxt;
  logic [7:0]                 stdout_nxt;
  logic                       stdout_en_nxt;
  logic [7:0]                 op;

  assign op        = prog_rval[7:0];
  assign prog_addr = pc;
  assign data_addr = dp;
  assign prog_ren  = en && (state == S_FETCH || state == S_SFETCH);
  assign data_ren  = en && (state == S_LOAD);
  assign data_wen  = en && (state == S_EXEC) && (ir == OP_INC || ir == OP_DEC);
  assign data_wval = (ir == OP_DEC) ? data_rval - V_ONE : data_rval + V_ONE;

  // Bracket nesting seen while scanning; the scan direction decides which bracket opens.
  always_comb begin
    scan_depth = depth;
    if (op == OP_OPEN)  scan_depth = back ? depth - P_ONE : depth + P_ONE;
    if (op == OP_CLOSE) scan_depth = back ? depth + P_ONE : depth - P_ONE;
  end

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    dp_nxt        = dp;
    depth_nxt     = depth;
    back_nxt      = back;
    ir_nxt        = ir;
    stdout_nxt    = stdout;
    stdout_en_nxt = 1'b0;
    case (state)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        ir_nxt = op;
        case (op)
          OP_HALT: state_nxt = S_HALT;
          OP_INC, OP_DEC, OP_OUT, OP_OPEN, OP_CLOSE: state_nxt = S_LOAD;
          default: begin
            if (op == OP_RIGHT) dp_nxt = dp + A_ONE;
            if (op == OP_LEFT)  dp_nxt = dp - A_ONE;
            pc_nxt    = pc + P_ONE;
            state_nxt = S_FETCH;
          end
        endcase
      end
      S_LOAD:   state_nxt = S_EXEC;
      S_EXEC: begin
        pc_nxt    = pc + P_ONE;
        state_nxt = S_FETCH;
        if (ir == OP_OUT) begin
          stdout_nxt    = data_rval[7:0];
          stdout_en_nxt = 1'b1;
        end
        if (ir == OP_OPEN && data_rval == '0) begin
          depth_nxt = P_ONE;
          back_nxt  = 1'b0;
          state_nxt = S_SFETCH;
        end
        if (ir == OP_CLOSE && data_rval != '0) begin
          depth_nxt = P_ONE;
          back_nxt  = 1'b1;
          pc_nxt    = pc - P_ONE;
          state_nxt = S_SFETCH;
        end
      end
      S_SFETCH: state_nxt = S_SDEC;
      S_SDEC: begin
        depth_nxt = scan_depth;
        if (op == OP_HALT) begin
          state_nxt = S_HALT;
        end else if (scan_depth == '0) begin
          // Both directions resume just past the bracket that closed the scan.
          pc_nxt    = pc + P_ONE;
          state_nxt = S_FETCH;
        end else begin
          pc_nxt    = back ? pc - P_ONE : pc + P_ONE;
          state_nxt = S_SFETCH;
        end
      end
      default:  state_nxt = S_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_FETCH;
      pc        <= '0;
      dp        <= '0;
      depth     <= '0;
      back      <= 1'b0;
      ir        <= '0;
      stdout    <= '0;
      stdout_en <= 1'b0;
    end else if (en) begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      dp        <= dp_nxt;
      depth     <= depth_nxt;
      back      <= back_nxt;
      ir        <= ir_nxt;
      stdout    <= stdout_nxt;
      stdout_en <= stdout_en_nxt;
    end
  end

endmodule

// File: tb/tb_bf_core.sv
// Directed bench for bf_core: ROM/RAM models, stdout scoreboard, cycle and control checks.
module tb_bf_core;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b1;
  logic [15:0] prog_addr;
  logic        prog_ren;
  logic [9:0]  prog_rval = '0;
  logic [15:0] data_addr;
  logic        data_ren, data_wen;
  logic [31:0] data_wval;
  logic [31:0] data_rval = '0;
  logic [7:0]  stdout;
  logic        stdout_en;

  bf_core dut (
    .clk(clk), .reset(reset), .en(en),
    .prog_addr(prog_addr), .prog_ren(prog_ren), .prog_rval(prog_rval),
    .data_addr(data_addr), .data_ren(data_ren), .data_wen(data_wen),
    .data_wval(data_wval), .data_rval(data_rval),
    .stdout(stdout), .stdout_en(stdout_en)
  );

  always #5 clk = ~clk;

  logic [9:0]  rom [0:255];
  logic [31:0] ram [0:65535];
  logic        ram_clr = 1'b0;

  always @(posedge clk) begin
    if (prog_ren) prog_rval <= rom[prog_addr[7:0]];
    if (data_ren) data_rval <= ram[data_addr];
    if (data_wen) ram[data_addr] <= data_wval;
    if (ram_clr) begin
      for (int i = 0; i < 16; i++) ram[i] <= '0;
      for (int i = 65520; i < 65536; i++) ram[i] <= '0;
    end
  end

  int          total = 0;
  int          bad = 0;
  logic [7:0]  exp_q[$];
  logic        strobe_q = 1'b0;
  int          wr0 = 0;
  logic [15:0] last_waddr = '0;
  logic [31:0] last_wval = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock step, sampled on the falling edge; also feeds the stdout scoreboard.
  task automatic tick();
    @(negedge clk);
    if (data_wen) begin
      if (data_addr == 16'h0) wr0++;
      last_waddr = data_addr;
      last_wval  = data_wval;
    end
    if (stdout_en && !strobe_q) begin
      total++;
      assert (exp_q.size() > 0) else begin
        bad++;
        $error("FAIL stdout_extra got=%02h exp=none", stdout);
      end
      if (exp_q.size() > 0) chk("stdout", stdout, exp_q.pop_front());
    end
    strobe_q = stdout_en;
  endtask

  task automatic load(input string s);
    logic [1:0] up;
    for (int i = 0; i < 256; i++) rom[i] = 10'h300;
    for (int i = 0; i < s.len(); i++) begin
      up = i[1:0];
      rom[i] = {up, s[i]};
    end
  endtask

  task automatic start();
    en = 1'b1;
    reset = 1'b1;
    ram_clr = 1'b1;
    @(posedge clk);
    #1 ram_clr = 1'b0;
    @(negedge clk);
    strobe_q = 1'b0;
    reset = 1'b0;
  endtask

  task automatic run_to_halt(input string tag);
    int zeros = 0;
    int c = 0;
    while (zeros < 6 && c < 3000) begin
      tick();
      c++;
      if (en && !prog_ren) zeros++;
      else zeros = 0;
    end
    chk({tag, "_halt"}, c < 3000, 1);
    chk({tag, "_drain"}, exp_q.size(), 0);
  endtask

  initial begin
    logic        ren_seen, any_en, moved;
    logic [15:0] pa, da;
    int          w0;

    // "+." cycle-exact, reset state checked while reset is held
    load("+.");
    en = 1'b1;
    reset = 1'b1;
    ram_clr = 1'b1;
    @(posedge clk);
    #1 ram_clr = 1'b0;
    chk("rst_paddr", prog_addr, 0);
    chk("rst_daddr", data_addr, 0);
    chk("rst_stdout", stdout, 0);
    chk("rst_stdout_en", stdout_en, 0);
    chk("rst_wen", data_wen, 0);
    @(negedge clk);
    strobe_q = 1'b0;
    reset = 1'b0;
    exp_q.push_back(8'h01);
    ren_seen = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      tick();
      if (c == 3) begin
        chk("a_wen_c3", data_wen, 1);
        chk("a_waddr_c3", data_addr, 0);
        chk("a_wval_c3", data_wval, 1);
      end
      if (c == 7) chk("a_sen_c7", stdout_en, 0);
      if (c == 8) chk("a_sen_c8", stdout_en, 1);
      if (c == 9) chk("a_sen_c9", stdout_en, 0);
      if (c >= 10 && prog_ren) ren_seen = 1'b1;
    end
    chk("a_halt_ren", ren_seen, 0);
    chk("a_drain", exp_q.size(), 0);
    #2 reset = 1'b1;
    #1 chk("a_rst_stdout", stdout, 0);

    // counted loop with backward scan
    load("+++[>+<-]>.");
    exp_q.push_back(8'h03);
    start();
    run_to_halt("b");
    chk("b_ram0", ram[0], 0);
    chk("b_ram1", ram[1], 3);

    // skipped loop on a zero cell
    load("[+].");
    exp_q.push_back(8'h00);
    start();
    w0 = wr0;
    run_to_halt("c");
    chk("c_no_wr0", wr0 - w0, 0);

    // nested loops
    load("++[>++[>+<-]<-]>>.");
    exp_q.push_back(8'h04);
    start();
    run_to_halt("d");
    chk("d_ram2", ram[2], 4);
    chk("d_ram1", ram[1], 0);

    // dp wraps below zero
    load("<+");
    start();
    run_to_halt("e");
    chk("e_waddr", last_waddr, 16'hFFFF);
    chk("e_wval", last_wval, 1);
    chk("e_ramffff", ram[65535], 1);

    // cell wraps below zero
    load("-");
    start();
    run_to_halt("f");
    chk("f_ram0", ram[0], 32'hFFFF_FFFF);

    // en held low mid-program, then after halt
    load("+++.>++.");
    exp_q.push_back(8'h03);
    exp_q.push_back(8'h02);
    start();
    repeat (9) tick();
    pa = prog_addr;
    da = data_addr;
    en = 1'b0;
    any_en = 1'b0;
    moved = 1'b0;
    repeat (10) begin
      tick();
      any_en = any_en | prog_ren | data_ren | data_wen;
      moved  = moved | (prog_addr != pa) | (data_addr != da);
    end
    chk("g_en_off", any_en, 0);
    chk("g_frozen", moved, 0);
    en = 1'b1;
    run_to_halt("g");
    en = 1'b0;
    repeat (10) tick();
    chk("g_stdout_hold", stdout, 8'h02);
    chk("g_sen_low", stdout_en, 0);
    en = 1'b1;

    // async reset during a loop, then full re-execution
    load(">++[-]<.");
    exp_q.push_back(8'h00);
    start();
    repeat (20) tick();
    chk("h_pre_dp", data_addr, 1);
    chk("h_pre_ren", data_ren, 1);
    #2 reset = 1'b1;
    #1;
    chk("h_rst_pc", prog_addr, 0);
    chk("h_rst_dp", data_addr, 0);
    chk("h_rst_ren", data_ren, 0);
    chk("h_rst_wen", data_wen, 0);
    @(negedge clk);
    strobe_q = 1'b0;
    reset = 1'b0;
    run_to_halt("h");
    chk("h_ram1", ram[1], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bf_core.md
Name: bf_core

Overview:
- Brainfuck-executing processor core that fetches 1-word instructions from an external synchronous program ROM.
- Reads and modifies cells in an external synchronous data RAM.
- Emits output bytes on a stdout strobe interface.
- Sits between program ROM, data RAM and a UART transmitter at the top level.

Parameters:
- DATA_ADDR_WIDTH, 16, data pointer / data RAM address width.
- DATA_VALUE_WIDTH, 32, data cell width.
- PROG_ADDR_WIDTH, 16, program counter / ROM address width; also the loop depth counter width.
- PROG_VALUE_WIDTH, 10, instruction word width (min 8).

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  run enable; 0 freezes the core.
- prog_addr  out  PROG_ADDR_WIDTH  ROM read address (= pc).
- prog_ren  out  1  ROM read enable.
- prog_rval  in  PROG_VALUE_WIDTH  ROM data, valid the cycle after an accepted read.
- data_addr  out  DATA_ADDR_WIDTH  RAM address, always = dp.
- data_ren  out  1  RAM read enable.
- data_wen  out  1  RAM write enable.
- data_wval  out  DATA_VALUE_WIDTH  RAM write data.
- data_rval  in  DATA_VALUE_WIDTH  RAM read data, valid the cycle after an accepted read.
- stdout  out  8  output byte.
- stdout_en  out  1  one-cycle strobe, stdout valid.

Behaviour:
- Memories: both are synchronous with 1-cycle read latency; rdata holds its value while ren=0. RAM writes take effect at the clock edge where data_wen=1.
- Instruction decode uses prog_rval[7:0] as ASCII; upper bits are ignored:
  - '>' 0x3E: dp+1.
  - '<' 0x3C: dp-1.
  - '+' 0x2B / '-' 0x2D: cell ±1.
  - '.' 0x2E: output cell[7:0].
  - '[' 0x5B, ']' 0x5D: loops.
  - ',' 0x2C: nop (no input port).
  - 0x00: HALT.
  - Any other value: nop.
- Reset (async): state=FETCH, pc=0, dp=0, depth=0, stdout=0, stdout_en=0.
- In all states, prog_ren, data_ren and data_wen are 0 unless stated below.
- Combinational outputs from state, gated by en:
  - prog_ren=1 in FETCH/SFETCH.
  - data_ren=1 in LOAD.
  - data_wen=1 in EXEC for '+'/'-'.
  - data_wval = data_rval+1 or data_rval-1.
- State machine (advances only on clk edges with en=1):
  - FETCH -> DECODE.
  - DECODE, '>'/'<'/nop: update dp, pc+1, -> FETCH.
  - DECODE, HALT -> HALT (terminal until reset).
  - DECODE, '+' '-' '.' '[' ']' -> LOAD.
  - LOAD -> EXEC (data_rval valid in EXEC).
  - EXEC, '+'/'-': write issued, pc+1 -> FETCH.
  - EXEC, '.': stdout<=data_rval[7:0], stdout_en<=1, pc+1 -> FETCH.
  - EXEC, '[': if data_rval==0, depth=1, pc+1, dir=fwd -> SFETCH; else pc+1 -> FETCH.
  - EXEC, ']': if data_rval!=0, depth=1, pc-1, dir=back -> SFETCH; else pc+1 -> FETCH.
  - SFETCH -> SDEC.
  - SDEC, forward scan: '[' depth+1; ']' depth-1.
  - SDEC, backward scan: ']' depth+1; '[' depth-1.
  - SDEC: if depth reaches 0, pc+1 -> FETCH. Forward this resumes after the matching ']'; backward it resumes after the matching '['.
  - SDEC otherwise: pc±1 per dir -> SFETCH.
  - SDEC, HALT word in either scan direction -> HALT (unbalanced program).
- stdout_en: high exactly one enabled cycle, then cleared. stdout holds the last byte.
- en=0: all registers hold, all enables are forced 0, and stdout_en holds its value. Execution resumes identically on en=1.
- Cycle counts: '>'/'<'/nop take 2 cycles; '+' '-' '.' '[' ']' take 4 cycles; each scanned instruction takes 2 cycles.
- Arithmetic wraps:
  - dp modulo 2^DATA_ADDR_WIDTH (dp=0, '<' gives all-ones).
  - Cells modulo 2^DATA_VALUE_WIDTH.
  - pc modulo 2^PROG_ADDR_WIDTH.
- Reset asserted mid-operation aborts any in-flight access; enables drop immediately.

Test Plan:
- ROM "+." then 0, RAM zeroed:
  - data_wen at cycle 3 with addr 0, wval 1.
  - stdout=0x01 and stdout_en high 1 cycle at cycle 8.
  - HALT follows, with prog_ren=0 forever.
- "+++[>+<-]>." -> single strobe stdout=0x03; RAM[0]=0, RAM[1]=3.
- "[+]." with cell0=0 -> loop body skipped, no write to addr 0, stdout=0x00.
- Nested "++[>++[>+<-]<-]>>." -> stdout=0x04; RAM[2]=4.
- "<+" -> write to addr 0xFFFF value 1; "-" on a 0 cell writes 0xFFFFFFFF.
- Control: en held low for 10 cycles mid-program leaves outputs frozen with enables 0 and the final stdout unchanged. Async reset mid-loop makes pc/dp return to 0 with no clock edge, and the program then re-executes from start.
